spi_slave_frame_ctrl: RTL and testbench
=======================================

Name: spi_slave_frame_ctrl

Overview:
Frame-level controller that sequences the byte-level SPI slave shifter into register-bus accesses. Each chip-select frame has the layout: command byte (R/W flag + start address), length byte, then N data bytes. Bytes are turned into burst writes or burst reads on a simple internal register bus, with auto-incrementing address. The block drives the shifter's direction flag and transmit byte, and sits between the SPI slave and the RFID register bank.

Parameters:
SPI_WIDTH, 8, byte width of shifter and register data
ADDR_W, 7, register address width; must be <= SPI_WIDTH-1
IDLE_BYTE, 8'hFF, value on tx_data_o whenever no read data is being served

Ports:
clk_i  in  1  system clock (100 MHz); single clock domain
rst_i  in  1  asynchronous reset, active-high
sncs_i  in  1  raw SPI chip select, active-low, asynchronous to clk_i
rx_byte_valid_i  in  1  one-cycle pulse from shifter: received byte complete
rx_data_i  in  SPI_WIDTH  received byte, valid with rx_byte_valid_i
tx_byte_done_i  in  1  one-cycle pulse from shifter: transmit byte consumed
tx_data_o  out  SPI_WIDTH  byte for the shifter to transmit
spi_wr_o  out  1  shifter direction: 1 = slave receives, 0 = slave transmits
reg_wr_o  out  1  one-cycle register write strobe
reg_rd_o  out  1  one-cycle register read strobe
reg_addr_o  out  ADDR_W  register address
reg_wdata_o  out  SPI_WIDTH  register write data
reg_rdata_i  in  SPI_WIDTH  register read data, valid exactly 1 cycle after reg_rd_o
busy_o  out  1  high whenever state != IDLE
frame_done_o  out  1  one-cycle pulse: frame completed with all N bytes served
frame_err_o  out  1  one-cycle pulse: frame aborted early or overrun

Behaviour:
- Reset (rst_i high, asynchronous): state IDLE; tx_data_o=IDLE_BYTE; spi_wr_o=1; all strobes and pulses 0; reg_addr_o, reg_wdata_o and the byte counter 0. Reset mid-frame aborts immediately with no pulses.
- sncs_i passes through a 2-FF synchroniser. Edges of the synchronised signal define frame start (falling) and frame end (rising).
- Byte counter is SPI_WIDTH bits wide. reg_addr_o increments modulo 2^ADDR_W (wraps from max to 0).
- IDLE: spi_wr_o=1. Synchronised CS falling edge -> CMD.
- CMD: on rx_byte_valid_i, latch rw=rx_data_i[SPI_WIDTH-1] and reg_addr_o=rx_data_i[ADDR_W-1:0] -> LEN.
- LEN: on rx_byte_valid_i, latch count=rx_data_i.
  - count==0 -> DONE; frame_done_o pulses on entry.
  - rw=0 -> WDATA.
  - rw=1 -> RPREF.
- WDATA: on rx_byte_valid_i, in the following cycle reg_wr_o=1, reg_wdata_o=byte, reg_addr_o=current address. Then address+1 and count-1. When count reaches 0 -> DONE with a frame_done_o pulse.
- RPREF: cycle 0 asserts reg_rd_o. Cycle 1 loads tx_data_o<=reg_rdata_i and sets spi_wr_o=0 -> RDATA. Total latency from LEN byte to tx_data_o valid is 3 clk_i cycles.
- RDATA: spi_wr_o=0. On tx_byte_done_i, count-1.
  - count==0 -> DONE with a frame_done_o pulse.
  - Otherwise address+1; reg_rd_o is pulsed the next cycle, and tx_data_o is updated from reg_rdata_i the cycle after.
  - tx_data_o holds its value between updates.
- DONE: spi_wr_o=1; tx_data_o=IDLE_BYTE. An extra rx_byte_valid_i (overrun) pulses frame_err_o once per frame and is otherwise ignored; no register access occurs.
- Any state except IDLE: a synchronised CS rising edge -> IDLE, spi_wr_o=1, tx_data_o=IDLE_BYTE. If in CMD (after byte 0), LEN, WDATA, RPREF or RDATA with count!=0, frame_err_o pulses. CS rising from CMD with no byte received is silent.
- Simultaneous CS rising edge and rx_byte_valid_i / tx_byte_done_i: CS wins. The byte is discarded, no reg_wr_o is issued, and frame_err_o pulses if count!=0.
- Timing constraint: SCLK half-period >= 4 clk_i cycles, so tx_data_o is settled before the next byte's first shift.
- At most one of reg_wr_o / reg_rd_o is high in any cycle.

Test Plan:
- Write burst: CS low, bytes 0x12, 0x03, AA, BB, CC, CS high -> reg_wr_o at addr 0x12/0x13/0x14 with AA/BB/CC; one frame_done_o; no frame_err_o; busy_o low after CS.
- Read burst: regs[0x05]=3C, regs[0x06]=C3; bytes 0x85, 0x02, then 2 transmit bytes -> reg_rd_o at 0x05 then 0x06; tx_data_o=3C then C3; spi_wr_o=0 only during RDATA; frame_done_o once.
- Address wrap: write 0x7F, len 2, data 11, 22 -> writes at 0x7F then 0x00.
- Early abort: write 0x20, len 4, only 2 data bytes, then CS high -> 2 writes (0x20, 0x21), one frame_err_o, no frame_done_o, state IDLE.
- Overrun and zero length: write len 1 followed by 2 data bytes -> 1 write, frame_done_o then a single frame_err_o. Separately, cmd 0x90, len 0 -> no reg access, immediate frame_done_o.
- Reset mid-read: assert rst_i during RDATA -> outputs at reset values in the same cycle; next frame after release behaves normally.

Source files
------------

// File: rtl/spi_slave_frame_ctrl.sv
// Frame controller between the byte-level SPI slave shifter and the register bank.
// A frame is a command byte {rw, addr}, a length byte, then a burst of data bytes.
module spi_slave_frame_ctrl #(
  parameter int                   SPI_WIDTH = 8,
  parameter int                   ADDR_W    = 7,
  parameter logic [SPI_WIDTH-1:0] IDLE_BYTE = 8'hFF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 sncs_i,
  input  logic                 rx_byte_valid_i,
  input  logic [SPI_WIDTH-1:0] rx_data_i,
  input  logic                 tx_byte_done_i,
  output logic [SPI_WIDTH-1:0] tx_data_o,
  output logic                 spi_wr_o,
  output logic                 reg_wr_o,
  output logic                 reg_rd_o,
  output logic [ADDR_W-1:0]    reg_addr_o,
  output logic [SPI_WIDTH-1:0] reg_wdata_o,
  input  logic [SPI_WIDTH-1:0] reg_rdata_i,
  output logic                 busy_o,
  output logic                 frame_done_o,
  output logic                 frame_err_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_LEN   = 3'd2,
    ST_WDATA = 3'd3,
    ST_RPREF = 3'd4,
    ST_RDATA = 3'd5,
    ST_DONE  = 3'd6
  } state_e;

  state_e               state_q;
  logic [2:0]           cs_sync_q;
  logic                 cs_rise_s;
  logic                 cs_fall_s;
  logic                 rw_q;
  logic [SPI_WIDTH-1:0] count_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [ADDR_W-1:0]    addr_d;
  logic [SPI_WIDTH-1:0] wdata_q;
  logic [SPI_WIDTH-1:0] tx_q;
  logic                 spi_wr_q;
  logic                 reg_wr_q;
  logic                 reg_rd_q;
  logic                 load_q;
  logic                 done_q;
  logic                 err_q;
  logic                 ovr_q;

  // cs_sync_q[1] is the synchronised chip select, cs_sync_q[2] its previous value.
  assign cs_rise_s = cs_sync_q[1] & ~cs_sync_q[2];
  assign cs_fall_s = ~cs_sync_q[1] & cs_sync_q[2];
  assign addr_d    = addr_q + ADDR_W'(1'b1);

  // Chip-select synchroniser and edge-detect history.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cs_sync_q <= 3'b111;
    end else begin
      cs_sync_q <= {cs_sync_q[1:0], sncs_i};
    end
  end

  // Frame sequencer with registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      rw_q     <= 1'b0;
      count_q  <= {SPI_WIDTH{1'b0}};
      addr_q   <= {ADDR_W{1'b0}};
      wdata_q  <= {SPI_WIDTH{1'b0}};
      tx_q     <= IDLE_BYTE;
      spi_wr_q <= 1'b1;
      reg_wr_q <= 1'b0;
      reg_rd_q <= 1'b0;
      load_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      reg_wr_q <= 1'b0;
      reg_rd_q <= 1'b0;
      load_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      // The address advances in the cycle after each write strobe.
      if (reg_wr_q) begin
        addr_q <= addr_d;
      end
      if (cs_rise_s && (state_q != ST_IDLE)) begin
        state_q  <= ST_IDLE;
        spi_wr_q <= 1'b1;
        tx_q     <= IDLE_BYTE;
        count_q  <= {SPI_WIDTH{1'b0}};
        err_q    <= (state_q == ST_LEN) || (state_q == ST_WDATA) ||
                    (state_q == ST_RPREF) || (state_q == ST_RDATA);
      end else begin
        case (state_q)
          ST_IDLE: begin
            spi_wr_q <= 1'b1;
            tx_q     <= IDLE_BYTE;
            if (cs_fall_s) begin
              state_q <= ST_CMD;
              ovr_q   <= 1'b0;
              count_q <= {SPI_WIDTH{1'b0}};
            end
          end
          ST_CMD: begin
            if (rx_byte_valid_i) begin
              rw_q    <= rx_data_i[SPI_WIDTH-1];
              addr_q  <= rx_data_i[ADDR_W-1:0];
              state_q <= ST_LEN;
            end
          end
          ST_LEN: begin
            if (rx_byte_valid_i) begin
              count_q <= rx_data_i;
              if (rx_data_i == {SPI_WIDTH{1'b0}}) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end else if (!rw_q) begin
                state_q <= ST_WDATA;
              end else begin
                state_q  <= ST_RPREF;
                reg_rd_q <= 1'b1;
              end
            end
          end
          ST_WDATA: begin
            if (rx_byte_valid_i) begin
              reg_wr_q <= 1'b1;
              wdata_q  <= rx_data_i;
              count_q  <= count_q - SPI_WIDTH'(1'b1);
              if (count_q == SPI_WIDTH'(1'b1)) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end
            end
          end
          ST_RPREF: begin
            if (reg_rd_q) begin
              load_q <= 1'b1;
            end else if (load_q) begin
              tx_q     <= reg_rdata_i;
              spi_wr_q <= 1'b0;
              state_q  <= ST_RDATA;
            end
          end
          ST_RDATA: begin
            if (reg_rd_q) begin
              load_q <= 1'b1;
            end
            if (load_q) begin
              tx_q <= reg_rdata_i;
            end
            if (tx_byte_done_i) begin
              count_q <= count_q - SPI_WIDTH'(1'b1);
              if (count_q == SPI_WIDTH'(1'b1)) begin
                state_q  <= ST_DONE;
                done_q   <= 1'b1;
                spi_wr_q <= 1'b1;
                tx_q     <= IDLE_BYTE;
              end else begin
                addr_q   <= addr_d;
                reg_rd_q <= 1'b1;
              end
            end
          end
          ST_DONE: begin
            spi_wr_q <= 1'b1;
            tx_q     <= IDLE_BYTE;
            if (rx_byte_valid_i && !ovr_q) begin
              err_q <= 1'b1;
              ovr_q <= 1'b1;
            end
          end
          default: begin
            state_q  <= ST_IDLE;
            spi_wr_q <= 1'b1;
            tx_q     <= IDLE_BYTE;
          end
        endcase
      end
    end
  end

  assign tx_data_o    = tx_q;
  assign spi_wr_o     = spi_wr_q;
  assign reg_wr_o     = reg_wr_q;
  assign reg_rd_o     = reg_rd_q;
  assign reg_addr_o   = addr_q;
  assign reg_wdata_o  = wdata_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign frame_done_o = done_q;
  assign frame_err_o  = err_q;

endmodule

// File: tb/tb_spi_slave_frame_ctrl.sv
// Self-checking bench: frames are driven byte by byte and checked against an
// arithmetic model of the expected bus accesses, read data and frame pulses.
module tb_spi_slave_frame_ctrl;

  logic       clk;
  logic       rst;
  logic       sncs;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_done;
  logic [7:0] tx_data;
  logic       spi_wr;
  logic       reg_wr;
  logic       reg_rd;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       busy;
  logic       fdone;
  logic       ferr;

  spi_slave_frame_ctrl dut (
    .clk_i(clk), .rst_i(rst), .sncs_i(sncs),
    .rx_byte_valid_i(rx_valid), .rx_data_i(rx_data), .tx_byte_done_i(tx_done),
    .tx_data_o(tx_data), .spi_wr_o(spi_wr), .reg_wr_o(reg_wr), .reg_rd_o(reg_rd),
    .reg_addr_o(reg_addr), .reg_wdata_o(reg_wdata), .reg_rdata_i(reg_rdata),
    .busy_o(busy), .frame_done_o(fdone), .frame_err_o(ferr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] bank_mem [0:127];
  logic [7:0] ref_mem  [0:127];
  logic [7:0] wbytes   [0:15];
  logic [14:0] wr_log [$];
  logic [6:0]  rd_log [$];
  int         n_done_pulse = 0;
  int         n_err_pulse  = 0;
  int         n_overlap    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Register bank: read data is presented exactly one cycle after the strobe.
  always @(posedge clk) begin
    if (reg_wr) bank_mem[reg_addr] <= reg_wdata;
    reg_rdata <= reg_rd ? bank_mem[reg_addr] : 8'h00;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (reg_wr) wr_log.push_back({reg_addr, reg_wdata});
      if (reg_rd) rd_log.push_back(reg_addr);
      if (fdone) n_done_pulse <= n_done_pulse + 1;
      if (ferr) n_err_pulse <= n_err_pulse + 1;
      if (reg_wr && reg_rd) n_overlap <= n_overlap + 1;
    end
  end

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_spi_wr"}, 32'(spi_wr), 32'd1);
    check_eq({tag, "_tx"}, 32'(tx_data), 32'hFF);
  endtask

  // nb = data bytes sent (write) or transmit bytes consumed (read, nb <= len).
  task automatic do_frame(input bit rw, input logic [6:0] a, input int len, input int nb);
    int w0, r0, d0, e0, nw, nr;
    logic [6:0] ai;
    w0 = wr_log.size(); r0 = rd_log.size(); d0 = n_done_pulse; e0 = n_err_pulse;
    nw = rw ? 0 : ((nb < len) ? nb : len);
    nr = !rw ? 0 : ((len == 0) ? 0 : ((nb < len) ? nb + 1 : len));
    @(negedge clk);
    sncs = 1'b0;
    repeat (4) @(negedge clk);
    send_rx({rw, a});
    send_rx(8'(len));
    if (!rw) begin
      for (int i = 0; i < nb; i++) send_rx(wbytes[i]);
      check_eq("wdata_dir", 32'(spi_wr), 32'd1);
    end else begin
      for (int i = 0; i < nb; i++) begin
        ai = a + 7'(i);
        check_eq("rd_dir", 32'(spi_wr), 32'd0);
        check_eq("rd_tx", 32'(tx_data), 32'(ref_mem[ai]));
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        repeat (10) @(negedge clk);
      end
    end
    check_eq("busy_in_frame", 32'(busy), 32'd1);
    sncs = 1'b1;
    repeat (6) @(negedge clk);
    check_idle_outputs("post_cs");
    check_eq("wr_cnt", 32'(wr_log.size() - w0), 32'(nw));
    for (int i = 0; i < nw; i++) begin
      ai = a + 7'(i);
      if (w0 + i < wr_log.size()) check_eq("wr_acc", 32'(wr_log[w0 + i]), 32'({ai, wbytes[i]}));
      ref_mem[ai] = wbytes[i];
    end
    check_eq("rd_cnt", 32'(rd_log.size() - r0), 32'(nr));
    for (int i = 0; i < nr; i++) begin
      ai = a + 7'(i);
      if (r0 + i < rd_log.size()) check_eq("rd_addr", 32'(rd_log[r0 + i]), 32'(ai));
    end
    check_eq("done_pulses", 32'(n_done_pulse - d0), (nb >= len) ? 32'd1 : 32'd0);
    check_eq("err_pulses", 32'(n_err_pulse - e0), (nb != len) ? 32'd1 : 32'd0);
  endtask

  initial begin
    int e0;
    int rlen;
    int rnb;
    bit rrw;
    rst = 1'b1; sncs = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_done = 1'b0;
    for (int i = 0; i < 128; i++) begin
      bank_mem[i] = 8'(i) ^ 8'h5A;
      ref_mem[i]  = 8'(i) ^ 8'h5A;
    end
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check_eq("reset_addr", 32'(reg_addr), 32'd0);
    check_eq("reset_strobes", 32'({reg_wr, reg_rd, fdone, ferr}), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    wbytes[0] = 8'hAA; wbytes[1] = 8'hBB; wbytes[2] = 8'hCC;
    do_frame(1'b0, 7'h12, 3, 3);
    wbytes[0] = 8'h3C; wbytes[1] = 8'hC3;
    do_frame(1'b0, 7'h05, 2, 2);
    do_frame(1'b1, 7'h05, 2, 2);
    wbytes[0] = 8'h11; wbytes[1] = 8'h22;
    do_frame(1'b0, 7'h7F, 2, 2);
    do_frame(1'b1, 7'h7F, 2, 2);
    wbytes[0] = 8'h44; wbytes[1] = 8'h55; wbytes[2] = 8'h66; wbytes[3] = 8'h77;
    do_frame(1'b0, 7'h20, 4, 2);
    do_frame(1'b0, 7'h30, 1, 2);
    do_frame(1'b0, 7'h31, 1, 3);
    do_frame(1'b1, 7'h10, 0, 0);
    do_frame(1'b1, 7'h40, 3, 1);

    // Reset in the middle of a read burst.
    e0 = n_err_pulse;
    @(negedge clk);
    sncs = 1'b0;
    repeat (4) @(negedge clk);
    send_rx(8'hD0);
    send_rx(8'h03);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_idle_outputs("mid_rst");
    check_eq("mid_rst_addr", 32'(reg_addr), 32'd0);
    check_eq("mid_rst_wdata", 32'(reg_wdata), 32'd0);
    check_eq("mid_rst_strobes", 32'({reg_wr, reg_rd, fdone, ferr}), 32'd0);
    @(negedge clk);
    sncs = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("mid_rst_no_err", 32'(n_err_pulse - e0), 32'd0);
    do_frame(1'b1, 7'h12, 3, 3);

    for (int k = 0; k < 20; k++) begin
      rrw  = 1'($urandom_range(0, 1));
      rlen = $urandom_range(0, 5);
      rnb  = rrw ? $urandom_range(0, rlen) : $urandom_range(0, rlen + 2);
      for (int i = 0; i < 16; i++) wbytes[i] = 8'($urandom);
      do_frame(rrw, 7'($urandom), rlen, rnb);
    end

    check_eq("one_strobe", 32'(n_overlap), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
